pipeline_ctrl: RTL

Central sequencer for the five-stage pipeline's register enables and flushes. It consumes the hazard unit's load-use stall, branch-redirect flush and unresolved-branch control hazard, plus data-memory busy. From these it drives per-stage write enables and flushes in a fixed priority order. A small FSM tracks branch-resolution and multi-cycle flush windows, and saturating counters expose stall and flush statistics.

---
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five-stage pipeline's register enables and flushes.
//
// Combines the hazard unit's requests and data-memory busy into per-stage write
// enables and flushes. A small FSM tracks the one-cycle branch-resolution window
// and multi-cycle flush windows. Two saturating counters expose statistics.
//
// Ports:
//   clk_i           clock, rising edge
//   rstn_i          asynchronous active-low reset
//   stall_i         load-use stall request
//   flush_i         taken branch/jump redirect, resolved in EX
//   ctrl_hazard_i   conditional branch in ID not yet resolved
//   dmem_busy_i     data memory not ready; freezes whole pipeline
//   pc_we_o         PC write enable
//   if_id_we_o      IF/ID write enable
//   if_id_flush_o   IF/ID clear to NOP
//   id_ex_we_o      ID/EX write enable
//   id_ex_flush_o   ID/EX clear to bubble
//   ex_mem_we_o     EX/MEM write enable
//   mem_wb_we_o     MEM/WB write enable
//   state_o         FSM state: RUN=0, BR_WAIT=1, FLUSH=2
//   stall_cnt_o     saturating count of stalled cycles
//   flush_cnt_o     saturating count of redirect events
`timescale 1ns / 1ps

module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,  // legal 1..4
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ctrl_hazard_i,
  input  logic             dmem_busy_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_we_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_we_o,
  output logic             mem_wb_we_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StBrWait = 2'd1,
    StFlush  = 2'd2
  } state_e;

  localparam logic [2:0]       FlushLoad = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;  // remaining flush cycles after the current one
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;

  always_comb begin
    pc_we_o       = 1'b1;
    if_id_we_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_we_o    = 1'b1;
    id_ex_flush_o = 1'b0;
    ex_mem_we_o   = 1'b1;
    mem_wb_we_o   = 1'b1;
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (dmem_busy_i) begin
      // Whole pipeline freezes; a pending redirect stays in EX and reasserts later.
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ex_mem_we_o = 1'b0;
      mem_wb_we_o = 1'b0;
      stall_inc   = 1'b1;
    end else if (flush_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      flush_inc     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        fcnt_d  = FlushLoad;
      end else begin
        state_d = StRun;
        fcnt_d  = 3'd0;
      end
    end else begin
      unique case (state_q)
        StRun, StBrWait: begin
          if (stall_i) begin
            pc_we_o       = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            stall_inc     = 1'b1;
            state_d       = StRun;
          end else if (ctrl_hazard_i && state_q == StRun) begin
            // Hold fetch and inject a NOP until the branch resolves in EX.
            pc_we_o       = 1'b0;
            if_id_flush_o = 1'b1;
            stall_inc     = 1'b1;
            state_d       = StBrWait;
          end else begin
            state_d = StRun;
          end
        end
        StFlush: begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (fcnt_q <= 3'd1) begin
            state_d = StRun;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = StRun;
          fcnt_d  = 3'd0;
        end
      endcase
    end

    // Reset forces a safe frozen-and-cleared pipeline regardless of inputs.
    if (!rstn_i) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_we_o    = 1'b0;
      id_ex_flush_o = 1'b1;
      ex_mem_we_o   = 1'b0;
      mem_wb_we_o   = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + CntOne;
    if (flush_inc && flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CntOne;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StRun;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
